// File: rtl/monopix_readout_ctrl.sv
// monopix_readout_ctrl
//   Token/read/freeze readout controller for one MONOPIX flavour. Runs the
//   matrix handshake, deserialises the DATA stream MSB first, gray-decodes the
//   LE/TE timestamps and buffers decoded hits in a first-word-fall-through FIFO.
//
// Ports
//   clk_bx     in   readout clock, all logic on posedge
//   rst_n      in   async active-low reset
//   enable     in   allows new transactions to start
//   token      in   matrix token (hit pending)
//   data_in    in   matrix serial data, MSB first
//   read       out  matrix READ pad drive (registered)
//   freeze     out  matrix FREEZE pad drive (registered)
//   busy       out  FSM not in IDLE
//   hit_col    out  FIFO head column
//   hit_row    out  FIFO head row
//   hit_le     out  FIFO head LE, binary
//   hit_te     out  FIFO head TE, binary
//   hit_valid  out  FIFO non-empty
//   hit_ready  in   consumer accepts head when hit_valid
//   fifo_full  out  FIFO holds FIFO_DEPTH words
//   drop_cnt   out  saturating count of words dropped on a full FIFO
//
// state        | meaning
// -------------+---------------------------------------------------------
// S_IDLE       | no transaction, waiting for enable & token
// S_TOKEN_WAIT | matrix frozen, settling; also holds here while FIFO full
// S_READ       | read pulse to the matrix
// S_DATA       | serial word shifted in, decoded word pushed
module monopix_readout_ctrl #(
  parameter int COL_W         = 6,
  parameter int ROW_W         = 9,
  parameter int TS_W          = 6,
  parameter int TOKEN_WAIT_C  = 2,
  parameter int READ_C        = 2,
  parameter int DATA_OFS      = 2,
  parameter int DATA_C        = 31,
  parameter int FIFO_DEPTH    = 8,
  parameter bit STALL_ON_FULL = 1'b1
) (
  input  logic             clk_bx,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             token,
  input  logic             data_in,
  output logic             read,
  output logic             freeze,
  output logic             busy,
  output logic [COL_W-1:0] hit_col,
  output logic [ROW_W-1:0] hit_row,
  output logic [TS_W-1:0]  hit_le,
  output logic [TS_W-1:0]  hit_te,
  output logic             hit_valid,
  input  logic             hit_ready,
  output logic             fifo_full,
  output logic [15:0]      drop_cnt
);

  localparam int WORD_W = COL_W + ROW_W + 2 * TS_W;
  localparam int CNT_W  = $clog2(DATA_C + TOKEN_WAIT_C + READ_C + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0] TW_LAST     = CNT_W'(TOKEN_WAIT_C - 1);
  localparam logic [CNT_W-1:0] RD_LAST     = CNT_W'(READ_C - 1);
  localparam logic [CNT_W-1:0] DATA_LAST   = CNT_W'(DATA_C - 1);
  localparam logic [CNT_W-1:0] SHIFT_FIRST = CNT_W'(DATA_OFS);
  localparam logic [CNT_W-1:0] SHIFT_LAST  = CNT_W'(DATA_OFS + WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_TOKEN_WAIT = 2'd1,
    S_READ       = 2'd2,
    S_DATA       = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] shreg;
  logic              shift_en;
  logic              word_done;
  logic [WORD_W-1:0] push_word;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              pop, wr_en, drop;
  logic [WORD_W-1:0] head;

  function automatic logic [TS_W-1:0] gray2bin(input logic [TS_W-1:0] g);
    logic [TS_W-1:0] b;
    b[TS_W-1] = g[TS_W-1];
    for (int i = TS_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk_bx or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (enable && token) state_next = S_TOKEN_WAIT;
      end
      S_TOKEN_WAIT: begin
        // cnt keeps counting while stalled, so compare with >= to leave as
        // soon as space opens up.
        if ((cnt >= TW_LAST) && !(STALL_ON_FULL && fifo_full)) state_next = S_READ;
      end
      S_READ: begin
        if (cnt == RD_LAST) state_next = S_DATA;
      end
      S_DATA: begin
        if (cnt == DATA_LAST) state_next = (enable && token) ? S_TOKEN_WAIT : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // cnt clears on every state entry and saturates at all-ones.
  always_ff @(posedge clk_bx or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_next != state) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_bx or negedge rst_n) begin
    if (!rst_n) begin
      read   <= 1'b0;
      freeze <= 1'b0;
    end else begin
      read   <= (state == S_READ);
      freeze <= (state == S_TOKEN_WAIT) || (state_next == S_READ);
    end
  end

  assign busy = (state != S_IDLE);

  // ---------------- deserialiser ----------------
  assign shift_en = (state == S_DATA) && (cnt >= SHIFT_FIRST) && (cnt <= SHIFT_LAST);

  always_ff @(posedge clk_bx or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      word_done <= 1'b0;
    end else begin
      if (shift_en) shreg <= {shreg[WORD_W-2:0], data_in};
      word_done <= shift_en && (cnt == SHIFT_LAST);
    end
  end

  // shreg layout: {col, row, le_gray, te_gray}
  assign push_word = {shreg[WORD_W-1 -: COL_W],
                      shreg[2*TS_W +: ROW_W],
                      gray2bin(shreg[TS_W +: TS_W]),
                      gray2bin(shreg[0 +: TS_W])};

  // ---------------- hit FIFO ----------------
  assign hit_valid = (occ != '0);
  assign fifo_full = (occ == OCC_W'(FIFO_DEPTH));
  assign pop       = hit_valid && hit_ready;
  assign wr_en     = word_done && (!fifo_full || pop);
  assign drop      = word_done && fifo_full && !pop && !STALL_ON_FULL;

  always_ff @(posedge clk_bx) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk_bx or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk_bx or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Storage is not reset; masking by hit_valid keeps hit_* at zero when empty.
  assign head    = mem[rd_ptr];
  assign hit_col = hit_valid ? head[WORD_W-1 -: COL_W] : '0;
  assign hit_row = hit_valid ? head[2*TS_W +: ROW_W]   : '0;
  assign hit_le  = hit_valid ? head[TS_W +: TS_W]      : '0;
  assign hit_te  = hit_valid ? head[0 +: TS_W]         : '0;

endmodule

// File: tb/tb_monopix_readout_ctrl.sv
// Directed bench for monopix_readout_ctrl. Instance 0 stalls on a full FIFO,
// instance 1 drops words on a full FIFO. A word is {col,row,le,te}.
module tb_monopix_readout_ctrl;

  logic       clk_bx = 1'b0;
  logic       rst_n;
  logic [1:0] enable, token, data_in, hit_ready;
  wire  [1:0] read_v, freeze_v, busy_v, valid_v, full_v;
  wire  [5:0] col0, col1, le0, le1, te0, te1;
  wire  [8:0] row0, row1;
  wire [15:0] drop0, drop1;
  wire [26:0] head0 = {col0, row0, le0, te0};
  wire [26:0] head1 = {col1, row1, le1, te1};

  int total = 0;
  int bad   = 0;
  int rd_cnt, frz_low, gap_frz_low, gap_busy_low;
  bit tmo;

  always #5 clk_bx = ~clk_bx;

  monopix_readout_ctrl #(.STALL_ON_FULL(1'b1)) dut_stall (
    .clk_bx(clk_bx), .rst_n(rst_n), .enable(enable[0]), .token(token[0]),
    .data_in(data_in[0]), .read(read_v[0]), .freeze(freeze_v[0]), .busy(busy_v[0]),
    .hit_col(col0), .hit_row(row0), .hit_le(le0), .hit_te(te0),
    .hit_valid(valid_v[0]), .hit_ready(hit_ready[0]), .fifo_full(full_v[0]),
    .drop_cnt(drop0)
  );

  monopix_readout_ctrl #(.STALL_ON_FULL(1'b0)) dut_drop (
    .clk_bx(clk_bx), .rst_n(rst_n), .enable(enable[1]), .token(token[1]),
    .data_in(data_in[1]), .read(read_v[1]), .freeze(freeze_v[1]), .busy(busy_v[1]),
    .hit_col(col1), .hit_row(row1), .hit_le(le1), .hit_te(te1),
    .hit_valid(valid_v[1]), .hit_ready(hit_ready[1]), .fifo_full(full_v[1]),
    .drop_cnt(drop1)
  );

  function automatic logic [26:0] mkw(input int c, input int r, input int l, input int t);
    return {6'(c), 9'(r), 6'(l), 6'(t)};
  endfunction

  function automatic logic [26:0] head(input int inst);
    return (inst == 0) ? head0 : head1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plays the matrix: waits for the READ pulse, then presents nbits of w MSB
  // first so that bit 0 lands on DATA cnt=2. Returns on the negedge at which
  // the last bit was driven.
  task automatic serve(input int inst, input logic [26:0] w, input int nbits, input bit drop_en);
    int n;
    rd_cnt = 0; frz_low = 0; gap_frz_low = 0; gap_busy_low = 0; tmo = 1'b0;
    n = 0;
    @(negedge clk_bx);
    while (read_v[inst] !== 1'b1) begin
      if (freeze_v[inst] == 1'b0) gap_frz_low++;
      if (busy_v[inst] == 1'b0) gap_busy_low++;
      n++;
      if (n > 300) begin
        tmo = 1'b1;
        return;
      end
      @(negedge clk_bx);
    end
    rd_cnt = 1;
    if (drop_en) enable[inst] = 1'b0;
    n = 0;
    @(negedge clk_bx);
    if (freeze_v[inst] == 1'b0) frz_low++;
    while (read_v[inst] === 1'b1) begin
      rd_cnt++;
      n++;
      if (n > 10) begin
        tmo = 1'b1;
        return;
      end
      @(negedge clk_bx);
      if (freeze_v[inst] == 1'b0) frz_low++;
    end
    @(negedge clk_bx);
    if (freeze_v[inst] == 1'b0) frz_low++;
    data_in[inst] = w[26];
    for (int i = 1; i < nbits; i++) begin
      @(negedge clk_bx);
      if (freeze_v[inst] == 1'b0) frz_low++;
      data_in[inst] = w[26-i];
    end
  endtask

  task automatic pop_check(input int inst, input logic [26:0] exp, input string tag);
    check({tag, "_valid"}, 32'(valid_v[inst]), 32'd1);
    check({tag, "_data"}, 32'(head(inst)), 32'(exp));
    hit_ready[inst] = 1'b1;
    @(negedge clk_bx);
    hit_ready[inst] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before the end of the sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_hi, read_hi;
    rst_n = 1'b0; enable = 2'b11; token = 2'b00; data_in = 2'b00; hit_ready = 2'b00;

    // ---- reset ----
    repeat (3) @(negedge clk_bx);
    check("rst_read",   32'(read_v),   32'd0);
    check("rst_freeze", 32'(freeze_v), 32'd0);
    check("rst_busy",   32'(busy_v),   32'd0);
    check("rst_valid",  32'(valid_v),  32'd0);
    check("rst_full",   32'(full_v),   32'd0);
    check("rst_drop1",  32'(drop1),    32'd0);
    rst_n = 1'b1;
    @(negedge clk_bx);
    check("rel_outs", 32'({read_v, freeze_v, busy_v, valid_v}), 32'd0);

    // ---- 1: single hit ----
    token[0] = 1'b1;
    @(negedge clk_bx);
    token[0] = 1'b0;
    check("t1_busy", 32'(busy_v[0]), 32'd1);
    check("t1_frz_early", 32'(freeze_v[0]), 32'd0);
    @(negedge clk_bx);
    check("t1_frz_lat2", 32'(freeze_v[0]), 32'd1);
    serve(0, mkw(5, 100, 6'b100000, 6'b100001), 27, 1'b0);
    check("t1_tmo", 32'(tmo), 32'd0);
    check("t1_read_len", 32'(rd_cnt), 32'd2);
    @(negedge clk_bx);
    check("t1_valid_early", 32'(valid_v[0]), 32'd0);
    @(negedge clk_bx);
    pop_check(0, mkw(5, 100, 63, 62), "t1_word");
    check("t1_empty", 32'(valid_v[0]), 32'd0);
    @(negedge clk_bx);
    check("t1_idle", 32'(busy_v[0]), 32'd0);

    // ---- 2: back-to-back, token held ----
    token[0] = 1'b1;
    serve(0, mkw(1, 2, 6'b000011, 6'b000010), 27, 1'b0);
    check("t2a_tmo", 32'(tmo), 32'd0);
    check("t2a_read_len", 32'(rd_cnt), 32'd2);
    check("t2a_frz_low", 32'(frz_low), 32'd29);
    serve(0, mkw(63, 511, 6'b110000, 6'b000111), 27, 1'b0);
    check("t2b_tmo", 32'(tmo), 32'd0);
    check("t2b_gap_frz_low", 32'(gap_frz_low), 32'd3);
    check("t2b_gap_idle", 32'(gap_busy_low), 32'd0);
    check("t2b_frz_low", 32'(frz_low), 32'd29);
    serve(0, mkw(0, 256, 6'b001000, 6'b000000), 27, 1'b0);
    token[0] = 1'b0;
    check("t2c_tmo", 32'(tmo), 32'd0);
    check("t2c_gap_frz_low", 32'(gap_frz_low), 32'd3);
    check("t2c_gap_idle", 32'(gap_busy_low), 32'd0);
    pop_check(0, mkw(1, 2, 2, 3), "t2_w0");
    pop_check(0, mkw(63, 511, 32, 5), "t2_w1");
    pop_check(0, mkw(0, 256, 15, 0), "t2_w2");
    check("t2_empty", 32'(valid_v[0]), 32'd0);
    repeat (3) @(negedge clk_bx);

    // ---- 3: stall on full ----
    token[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      serve(0, mkw(10 + i, 7 * i, 0, 1), 27, 1'b0);
      check("t3_fill_tmo", 32'(tmo), 32'd0);
    end
    repeat (20) @(negedge clk_bx);
    check("t3_full", 32'(full_v[0]), 32'd1);
    check("t3_freeze_held", 32'(freeze_v[0]), 32'd1);
    check("t3_busy", 32'(busy_v[0]), 32'd1);
    check("t3_no_read", 32'(read_v[0]), 32'd0);
    pop_check(0, mkw(10, 0, 0, 1), "t3_p0");
    serve(0, mkw(18, 56, 0, 1), 27, 1'b0);
    check("t3_w8_tmo", 32'(tmo), 32'd0);
    pop_check(0, mkw(11, 7, 0, 1), "t3_p1");
    pop_check(0, mkw(12, 14, 0, 1), "t3_p2");
    serve(0, mkw(19, 63, 0, 1), 27, 1'b0);
    token[0] = 1'b0;
    check("t3_w9_tmo", 32'(tmo), 32'd0);
    repeat (2) @(negedge clk_bx);
    for (int i = 3; i < 10; i++) pop_check(0, mkw(10 + i, 7 * i, 0, 1), "t3_pn");
    check("t3_empty", 32'(valid_v[0]), 32'd0);

    // ---- 4: drop on full ----
    token[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      serve(1, mkw(20 + i, 3 * i + 1, 0, 1), 27, 1'b0);
      check("t4_tmo", 32'(tmo), 32'd0);
    end
    repeat (3) @(negedge clk_bx);
    check("t4_full", 32'(full_v[1]), 32'd1);
    check("t4_drop_cnt", 32'(drop1), 32'd2);
    serve(1, mkw(40, 400, 0, 1), 27, 1'b0);
    check("t4_w10_tmo", 32'(tmo), 32'd0);
    @(negedge clk_bx);
    check("t4_head_w0", 32'(head1), 32'(mkw(20, 1, 0, 1)));
    hit_ready[1] = 1'b1;
    @(negedge clk_bx);
    hit_ready[1] = 1'b0;
    token[1] = 1'b0;
    check("t4_full_after_swap", 32'(full_v[1]), 32'd1);
    check("t4_drop_same", 32'(drop1), 32'd2);
    for (int i = 1; i < 8; i++) pop_check(1, mkw(20 + i, 3 * i + 1, 0, 1), "t4_pn");
    pop_check(1, mkw(40, 400, 0, 1), "t4_swapped");
    check("t4_empty", 32'(valid_v[1]), 32'd0);

    // ---- 5: reset mid-DATA ----
    token[0] = 1'b1;
    serve(0, mkw(9, 9, 0, 1), 27, 1'b0);
    serve(0, mkw(50, 50, 0, 1), 9, 1'b0);
    check("t5_pre_valid", 32'(valid_v[0]), 32'd1);
    check("t5_pre_busy", 32'(busy_v[0]), 32'd1);
    rst_n = 1'b0;
    token[0] = 1'b0;
    #1;
    check("t5_read", 32'(read_v[0]), 32'd0);
    check("t5_freeze", 32'(freeze_v[0]), 32'd0);
    check("t5_valid", 32'(valid_v[0]), 32'd0);
    check("t5_busy", 32'(busy_v[0]), 32'd0);
    check("t5_drop1_clr", 32'(drop1), 32'd0);
    repeat (2) @(negedge clk_bx);
    rst_n = 1'b1;
    @(negedge clk_bx);
    check("t5_rel", 32'({read_v[0], freeze_v[0], busy_v[0], valid_v[0]}), 32'd0);
    token[0] = 1'b1;
    @(negedge clk_bx);
    token[0] = 1'b0;
    serve(0, mkw(33, 300, 6'b000011, 6'b110000), 27, 1'b0);
    check("t5_tmo", 32'(tmo), 32'd0);
    repeat (2) @(negedge clk_bx);
    pop_check(0, mkw(33, 300, 2, 32), "t5_clean");
    check("t5_empty", 32'(valid_v[0]), 32'd0);

    // ---- 6: enable dropped during READ ----
    token[0] = 1'b1;
    serve(0, mkw(17, 77, 6'b000010, 6'b000011), 27, 1'b1);
    check("t6_tmo", 32'(tmo), 32'd0);
    repeat (2) @(negedge clk_bx);
    pop_check(0, mkw(17, 77, 3, 2), "t6_word");
    busy_hi = 0;
    read_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_bx);
      if (busy_v[0]) busy_hi++;
      if (read_v[0]) read_hi++;
    end
    check("t6_idle", 32'(busy_hi), 32'd0);
    check("t6_no_read", 32'(read_hi), 32'd0);
    check("t6_empty", 32'(valid_v[0]), 32'd0);
    token[0] = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
